// File: rtl/std_reg_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time onto a shared
// enable-gated register, acks the winner, then holds off for GAP cycles.
module std_reg_wr_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GAP     = 1,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     reg_en,
    output logic [WIDTH-1:0]         reg_d,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 reg_en_q, reg_en_d;
    logic [WIDTH-1:0]     reg_d_q, reg_d_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;

    logic                 found;
    logic [IDW-1:0]       win;
    int unsigned          idx;

    // Round-robin scan starting at ptr; first pending requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        reg_en_d   = 1'b0;
        ack_d      = '0;
        reg_d_d    = reg_d_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    state_d    = WRITE;
                    reg_en_d   = 1'b1;
                    ack_d      = NUM_REQ'(1) << win;
                    reg_d_d    = wdata[32'(win)*WIDTH +: WIDTH];
                    grant_id_d = win;
                    busy_d     = 1'b1;
                end
            end
            WRITE: begin
                ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
                if (GAP == 0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = CW'(GAP - 1);
                    state_d = COOLDOWN;
                    busy_d  = 1'b1;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            reg_en_q   <= 1'b0;
            reg_d_q    <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign reg_en   = reg_en_q;
    assign reg_d    = reg_d_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_std_reg_wr_arbiter.sv
// Directed bench for std_reg_wr_arbiter: GAP=1 instance for the main
// sequence, GAP=0 instance for back-to-back spacing.
module tb_std_reg_wr_arbiter;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDW     = 2;

    logic                     clk = 1'b0;
    logic                     rst, rst0;
    logic [NUM_REQ-1:0]       req, req0;
    logic [NUM_REQ*WIDTH-1:0] wdata, wdata0;
    logic [NUM_REQ-1:0]       ack, ack0;
    logic                     reg_en, reg_en0;
    logic [WIDTH-1:0]         reg_d, reg_d0;
    logic [IDW-1:0]           grant_id, grant_id0;
    logic                     busy, busy0;
    logic [WIDTH-1:0]         shadow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    std_reg_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .GAP(1)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack),
        .reg_en(reg_en), .reg_d(reg_d), .grant_id(grant_id), .busy(busy)
    );

    std_reg_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .GAP(0)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .wdata(wdata0), .ack(ack0),
        .reg_en(reg_en0), .reg_d(reg_d0), .grant_id(grant_id0), .busy(busy0)
    );

    // Downstream enable-DFF fed by the GAP=1 instance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow <= '0;
        else if (reg_en) shadow <= reg_d;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Hold all four requests and check ack order/spacing starting from ptr=0.
    task automatic run_fair(input bit use_gap0, input int spacing, input int n);
        int order [5];
        int k;
        int last;
        logic [NUM_REQ-1:0] a;
        order = '{0, 1, 2, 3, 0};
        k = 0;
        last = 0;
        for (int c = 1; c <= 40 && k < n; c++) begin
            step();
            a = use_gap0 ? ack0 : ack;
            if (a != '0) begin
                check($sformatf("fair%0d_ack%0d", spacing, k), 64'(a), 64'(4'b1 << order[k]));
                if (k == 0) check($sformatf("fair%0d_latency", spacing), 64'(c), 64'd1);
                else        check($sformatf("fair%0d_gap%0d", spacing, k), 64'(c - last), 64'(spacing));
                last = c;
                k++;
            end
        end
        check($sformatf("fair%0d_count", spacing), 64'(k), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst0 = 1'b1;
        req = '0; req0 = '0;
        wdata = '0; wdata0 = '0;
        step();
        check("rst_reg_en", 64'(reg_en), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_reg_d", 64'(reg_d), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        rst = 1'b0;
        step();

        // Single request from index 2
        req = 4'b0100;
        wdata[2*WIDTH +: WIDTH] = 16'hA5A5;
        step();
        check("single_reg_en", 64'(reg_en), 64'd1);
        check("single_reg_d", 64'(reg_d), 64'hA5A5);
        check("single_ack", 64'(ack), 64'b0100);
        check("single_grant", 64'(grant_id), 64'd2);
        check("single_busy1", 64'(busy), 64'd1);
        req = '0;
        step();
        check("single_cool_en", 64'(reg_en), 64'd0);
        check("single_cool_ack", 64'(ack), 64'd0);
        check("single_busy2", 64'(busy), 64'd1);
        check("single_shadow", 64'(shadow), 64'hA5A5);
        check("single_hold_d", 64'(reg_d), 64'hA5A5);
        step();
        check("single_busy3", 64'(busy), 64'd0);
        check("single_hold_gid", 64'(grant_id), 64'd2);

        // Wrap-around: grant 3, then req 1001 goes to 0 before 3
        req = 4'b1000;
        step();
        check("wrap_first", 64'(ack), 64'b1000);
        req = '0;
        step(); step();
        req = 4'b1001;
        step();
        check("wrap_a", 64'(ack), 64'b0001);
        req = 4'b1000;
        step(); step();
        check("wrap_idle", 64'(reg_en), 64'd0);
        step();
        check("wrap_b", 64'(ack), 64'b1000);
        req = '0;
        step(); step();

        // Capture: winner changes data and drops req right after the grant edge
        req = 4'b0010;
        wdata[1*WIDTH +: WIDTH] = 16'h1111;
        @(posedge clk); #1;
        wdata[1*WIDTH +: WIDTH] = 16'h2222;
        req = '0;
        step();
        check("cap_reg_d", 64'(reg_d), 64'h1111);
        check("cap_ack", 64'(ack), 64'b0010);
        step();
        check("cap_shadow", 64'(shadow), 64'h1111);
        step();

        // Late arrival during COOLDOWN (ptr now 2; lone req 0 wins first)
        req = 4'b0001;
        step();
        check("late_first", 64'(ack), 64'b0001);
        req = '0;
        step();
        check("late_cool_busy", 64'(busy), 64'd1);
        req = 4'b0010;
        wdata[1*WIDTH +: WIDTH] = 16'h3C3C;
        step();
        check("late_idle_en", 64'(reg_en), 64'd0);
        check("late_idle_busy", 64'(busy), 64'd0);
        step();
        check("late_en", 64'(reg_en), 64'd1);
        check("late_ack", 64'(ack), 64'b0010);
        check("late_grant", 64'(grant_id), 64'd1);
        check("late_reg_d", 64'(reg_d), 64'h3C3C);

        // Reset mid-COOLDOWN with requests still pending
        req = 4'b1111;
        step();
        check("mid_cool_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_en", 64'(reg_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_d", 64'(reg_d), 64'd0);
        check("mid_rst_gid", 64'(grant_id), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        req = '0;
        step();
        rst = 1'b0;
        req = 4'b1111;
        run_fair(1'b0, 3, 5);
        req = '0;

        // Back-to-back with no cooldown
        rst0 = 1'b0;
        step();
        req0 = 4'b1111;
        run_fair(1'b1, 2, 5);
        req0 = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
